ft232h_rx: RTL and testbench

//  Read-side controller for the FT232H in FT245 synchronous FIFO mode. Pulls host-to-device bytes

---
 rtl/ft232h_rx_if.sv | 28 ++
 rtl/ft232h_rx.sv | 124 ++++++++++++
 tb/tb_ft232h_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ft232h_rx_if.sv
// Signal bundle between the FT232H read controller, the FTDI pins and the AXI-Stream sink.
// master = controller side, slave = FTDI/sink side.
interface ft232h_rx_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   ftdi_rxf_n;
  logic [7:0]             ftdi_data_in;
  logic                   ftdi_oe_n;
  logic                   ftdi_rd_n;
  // AXIS: a byte moves on a rising edge where m_tvalid & m_tready; once m_tvalid is high,
  // m_tdata holds and m_tvalid stays high until that transfer happens.
  logic [7:0]             m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   rx_active;
  logic [COUNT_WIDTH-1:0] rx_byte_count;
  logic [1:0]             dbg_state;

  modport master (
    input  ftdi_rxf_n, ftdi_data_in, m_tready,
    output ftdi_oe_n, ftdi_rd_n, m_tdata, m_tvalid, rx_active, rx_byte_count, dbg_state
  );

  modport slave (
    output ftdi_rxf_n, ftdi_data_in, m_tready,
    input  ftdi_oe_n, ftdi_rd_n, m_tdata, m_tvalid, rx_active, rx_byte_count, dbg_state
  );
endinterface

// File: rtl/ft232h_rx.sv
// FT245 synchronous-FIFO read controller: drains FTDI bytes into a skid FIFO and
// presents them as an AXI-Stream master, all on ftdi_clk.
module ft232h_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic          ftdi_clk,
  input  logic          rst,
  ft232h_rx_if.master   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] C_DEPTH    = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] C_DEPTH_M1 = (PW+1)'(FIFO_DEPTH - 1);
  localparam logic [PW:0] C_DEPTH_M2 = (PW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OE_WAIT = 2'd1,
    READING = 2'd2
  } state_t;

  state_t                 r_state, w_state_next;
  logic                   r_oe_n, r_rd_n, w_oe_n_next, w_rd_n_next;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [PW:0]            r_count, w_count_next;
  logic [COUNT_WIDTH-1:0] r_byte_count;
  logic                   w_capture, w_pop, w_valid;

  assign w_valid      = (r_count != '0);
  assign w_capture    = (r_state == READING) & ~r_rd_n & ~bus.ftdi_rxf_n;
  assign w_pop        = w_valid & bus.m_tready;
  assign w_count_next = r_count + {{PW{1'b0}}, w_capture} - {{PW{1'b0}}, w_pop};

  // Leaving READING is decided on count_next, so the last capture can fill the FIFO
  // but never overflow it.
  always_comb begin
    w_state_next = r_state;
    w_oe_n_next  = r_oe_n;
    w_rd_n_next  = r_rd_n;
    unique case (r_state)
      IDLE: begin
        w_rd_n_next = 1'b1;
        if (!bus.ftdi_rxf_n && r_count <= C_DEPTH_M2) begin
          w_state_next = OE_WAIT;
          w_oe_n_next  = 1'b0;
        end else begin
          w_oe_n_next  = 1'b1;
        end
      end
      OE_WAIT: begin
        w_rd_n_next = 1'b1;
        if (!bus.ftdi_rxf_n && w_count_next <= C_DEPTH_M1) begin
          w_state_next = READING;
          w_oe_n_next  = 1'b0;
          w_rd_n_next  = 1'b0;
        end else begin
          w_state_next = IDLE;
          w_oe_n_next  = 1'b1;
        end
      end
      READING: begin
        if (bus.ftdi_rxf_n || w_count_next >= C_DEPTH) begin
          w_state_next = IDLE;
          w_oe_n_next  = 1'b1;
          w_rd_n_next  = 1'b1;
        end else begin
          w_oe_n_next  = 1'b0;
          w_rd_n_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_oe_n_next  = 1'b1;
        w_rd_n_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_oe_n  <= 1'b1;
      r_rd_n  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_oe_n  <= w_oe_n_next;
      r_rd_n  <= w_rd_n_next;
    end
  end

  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_byte_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_capture) begin
        r_wr_ptr     <= r_wr_ptr + PW'(1);
        r_byte_count <= r_byte_count + COUNT_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by r_count and the output is gated on it.
  always_ff @(posedge ftdi_clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= bus.ftdi_data_in;
    end
  end

  assign bus.ftdi_oe_n     = r_oe_n;
  assign bus.ftdi_rd_n     = r_rd_n;
  assign bus.m_tvalid      = w_valid;
  assign bus.m_tdata       = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.rx_active     = (r_state != IDLE);
  assign bus.rx_byte_count = r_byte_count;
  assign bus.dbg_state     = r_state;
endmodule

// File: tb/tb_ft232h_rx.sv
// Bench for ft232h_rx: an FTDI source model feeds bytes, a scoreboard checks stream order,
// occupancy, byte counts (16-bit and a 4-bit twin instance) and the pin handshake timing.
module tb_ft232h_rx;
  logic ftdi_clk = 1'b0;
  logic rst      = 1'b1;

  always #8 ftdi_clk = ~ftdi_clk;

  ft232h_rx_if #(.COUNT_WIDTH(16)) dut_if ();
  ft232h_rx_if #(.COUNT_WIDTH(4))  dut4_if ();

  ft232h_rx #(.FIFO_DEPTH(8), .COUNT_WIDTH(16)) u_dut (
    .ftdi_clk (ftdi_clk),
    .rst      (rst),
    .bus      (dut_if)
  );

  ft232h_rx #(.FIFO_DEPTH(8), .COUNT_WIDTH(4)) u_dut4 (
    .ftdi_clk (ftdi_clk),
    .rst      (rst),
    .bus      (dut4_if)
  );

  assign dut4_if.ftdi_rxf_n   = dut_if.ftdi_rxf_n;
  assign dut4_if.ftdi_data_in = dut_if.ftdi_data_in;
  assign dut4_if.m_tready     = dut_if.m_tready;

  // reference model state
  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  int          model_cnt;
  logic [31:0] cap_total;
  logic [31:0] cap_limit;
  int          tready_mode;
  bit          rand_gap;
  logic        prev_rd_n, prev_rxf_n, prev_hs;
  int          n_total, n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: at the falling edge, account for what the last rising edge did,
  // drive new inputs, then check outputs against the model.
  task automatic step();
    logic [7:0] b;
    @(negedge ftdi_clk);
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
      cap_total = 0;
    end else begin
      if (!prev_rd_n && !prev_rxf_n) begin
        b = src_q.pop_front();
        exp_q.push_back(b);
        model_cnt++;
        cap_total++;
      end
      if (prev_hs) model_cnt--;
    end

    dut_if.ftdi_rxf_n   = !(src_q.size() != 0 && cap_total < cap_limit &&
                            !(rand_gap && $urandom_range(0, 3) == 0));
    dut_if.ftdi_data_in = (src_q.size() != 0) ? src_q[0] : 8'h00;
    case (tready_mode)
      0:       dut_if.m_tready = 1'b0;
      1:       dut_if.m_tready = 1'b1;
      default: dut_if.m_tready = 1'($urandom_range(0, 1));
    endcase

    if (!rst) begin
      check("rd_without_oe", 32'(!dut_if.ftdi_rd_n && dut_if.ftdi_oe_n), 0);
      check("rx_active", 32'(dut_if.rx_active), 32'(!dut_if.ftdi_oe_n));
      check("tvalid", 32'(dut_if.m_tvalid), 32'(model_cnt != 0));
      check("tvalid4", 32'(dut4_if.m_tvalid), 32'(model_cnt != 0));
      check("occupancy", 32'(model_cnt <= 8), 1);
      check("byte_count", 32'(dut_if.rx_byte_count), 32'(cap_total[15:0]));
      check("byte_count4", 32'(dut4_if.rx_byte_count), 32'(cap_total[3:0]));
      if (dut_if.m_tvalid && dut_if.m_tready) begin
        check("exp_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("tdata", 32'(dut_if.m_tdata), 32'(b));
          check("tdata4", 32'(dut4_if.m_tdata), 32'(b));
        end
      end
    end

    prev_hs    = !rst && dut_if.m_tvalid && dut_if.m_tready;
    prev_rd_n  = rst ? 1'b1 : dut_if.ftdi_rd_n;
    prev_rxf_n = dut_if.ftdi_rxf_n;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || model_cnt != 0 || dut_if.rx_active) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n < budget), 1);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [31:0] start;
    int          n;
    n_total     = 0;
    n_bad       = 0;
    model_cnt   = 0;
    cap_total   = 0;
    cap_limit   = 32'hFFFF_FFFF;
    tready_mode = 1;
    rand_gap    = 0;
    prev_rd_n   = 1'b1;
    prev_rxf_n  = 1'b1;
    prev_hs     = 1'b0;
    dut_if.ftdi_rxf_n   = 1'b1;
    dut_if.ftdi_data_in = 8'h00;
    dut_if.m_tready     = 1'b0;

    // reset, then idle with no data available
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) begin
      step();
      check("idle_oe_n", 32'(dut_if.ftdi_oe_n), 1);
      check("idle_rd_n", 32'(dut_if.ftdi_rd_n), 1);
      check("idle_tvalid", 32'(dut_if.m_tvalid), 0);
      check("idle_count", 32'(dut_if.rx_byte_count), 0);
    end

    // 16-byte burst 0x00..0x0F with startup latency
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    step();
    step();
    check("lat_edge1_oe_n", 32'(dut_if.ftdi_oe_n), 0);
    check("lat_edge1_rd_n", 32'(dut_if.ftdi_rd_n), 1);
    step();
    check("lat_edge2_rd_n", 32'(dut_if.ftdi_rd_n), 0);
    check("lat_edge2_caps", cap_total, 0);
    step();
    check("lat_edge3_caps", cap_total, 1);
    drain(100);
    check("burst16_count", 32'(dut_if.rx_byte_count), 16);
    check("burst16_idle", 32'(dut_if.rx_active), 0);

    // sink stalled: exactly FIFO_DEPTH bytes taken, then resume once count <= 6
    tready_mode = 0;
    start = cap_total;
    push_random(12);
    repeat (30) step();
    check("stall_caps", cap_total - start, 8);
    check("stall_oe_n", 32'(dut_if.ftdi_oe_n), 1);
    check("stall_rd_n", 32'(dut_if.ftdi_rd_n), 1);
    check("stall_left", 32'(src_q.size()), 4);
    tready_mode = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (dut_if.ftdi_oe_n && n < 20);
    check("resume_timeout", 32'(n < 20), 1);
    check("resume_level", 32'(model_cnt), 5);
    step();
    check("resume_rd_n", 32'(dut_if.ftdi_rd_n), 0);
    drain(100);

    // rxf_n rises after 5 captures
    start     = cap_total;
    cap_limit = cap_total + 5;
    push_random(8);
    n = 0;
    while (cap_total != cap_limit && n < 30) begin
      step();
      n++;
    end
    check("rxf_rise_timeout", 32'(n < 30), 1);
    step();
    check("rxf_rise_rd_n", 32'(dut_if.ftdi_rd_n), 1);
    check("rxf_rise_active", 32'(dut_if.rx_active), 0);
    repeat (5) step();
    check("rxf_rise_caps", cap_total - start, 5);
    check("rxf_rise_left", 32'(src_q.size()), 3);
    cap_limit = 32'hFFFF_FFFF;
    drain(100);

    // reset in the middle of a burst
    start = cap_total;
    push_random(20);
    n = 0;
    while (cap_total - start < 3 && n < 30) begin
      step();
      n++;
    end
    check("mid_rst_reach", 32'(dut_if.ftdi_rd_n), 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_oe_n", 32'(dut_if.ftdi_oe_n), 1);
    check("mid_rst_rd_n", 32'(dut_if.ftdi_rd_n), 1);
    check("mid_rst_tvalid", 32'(dut_if.m_tvalid), 0);
    check("mid_rst_active", 32'(dut_if.rx_active), 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_oe_n", 32'(dut_if.ftdi_oe_n), 0);
    check("post_rst_rd_n", 32'(dut_if.ftdi_rd_n), 1);
    step();
    check("post_rst_reading", 32'(dut_if.ftdi_rd_n), 0);
    drain(200);

    // count wrap on the 4-bit instance: 17 bytes from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    tready_mode = 2;
    push_random(17);
    drain(300);
    check("wrap_count16", 32'(dut_if.rx_byte_count), 17);
    check("wrap_count4", 32'(dut4_if.rx_byte_count), 1);

    // randomized traffic: random stalls on both sides
    rand_gap = 1;
    push_random(300);
    drain(4000);
    rand_gap = 0;
    tready_mode = 1;
    drain(100);
    check("final_exp_empty", 32'(exp_q.size()), 0);
    check("final_tvalid", 32'(dut_if.m_tvalid), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
